regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive load grants while an ALU entry waits (range 1-3).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports alu_req input 1, alu_rd input 4, alu_data input 16, alu_ack output 1: ALU writeback channel.
REQ-005 SHALL have ports ld_req input 1, ld_rd input 4, ld_data input 16, ld_ack output 1: load writeback channel.
REQ-006 SHALL have ports iss_valid input 1, iss_rd input 4: an instruction issued that will write iss_rd.
REQ-007 SHALL have ports rs_q input 4, rt_q input 4, rs_busy output 1, rt_busy output 1: scoreboard query.
REQ-008 SHALL have ports rf_wr output 1, rf_rd output 4, rf_rw output 16: registered drive to register-file wr/Rd/RW.
REQ-009 SHALL have ports byp_rs_hit output 1, byp_rt_hit output 1, byp_data output 16: writeback bypass.

Function
REQ-010 SHALL hold one holding entry per channel (valid, rd, data); transfer occurs at a rising edge when req=1 and ack=1.
REQ-011 SHALL drive ack = ~hold_valid | (entry granted this cycle); ack SHALL NOT depend combinationally on req.
REQ-012 SHALL grant at most one holding entry per cycle; grant SHALL register rf_wr=1, rf_rd, rf_rw at that edge and free the entry.
REQ-013 SHALL give latency: handshake edge E0 -> rf_wr high after E1 -> register-file write at E2; sustained throughput one write per cycle.
REQ-014 SHALL drive rf_wr=0 (rf_rd, rf_rw hold last value) in cycles with no grant.
REQ-015 SHALL select grant via FSM states PRI_LD (load preferred) and PRI_ALU (ALU preferred); reset state PRI_LD.
REQ-016 SHALL in PRI_LD keep a 2-bit starve counter incremented on each load grant while the ALU entry is valid; counter reaching STARVE_LIMIT moves the FSM to PRI_ALU.
REQ-017 SHALL in PRI_ALU grant the ALU entry if valid, then return to PRI_LD with counter=0; counter SHALL also clear whenever the ALU entry is empty.
REQ-018 SHALL, when both entries are valid with equal rd, grant the older entry regardless of FSM state; entries captured on the same edge order load first, ALU second.
REQ-019 SHALL maintain a 16-bit busy vector: iss_valid sets busy[iss_rd]; a grant clears busy[rf_rd] at the same edge it drives rf_wr.
REQ-020 SHALL give set priority when iss_valid targets the rd being cleared on the same edge (busy stays 1).
REQ-021 SHALL drive rs_busy=busy[rs_q], rt_busy=busy[rt_q] combinationally.
REQ-022 SHALL treat register 0 like any other register (no hard-wired zero).

Reset
REQ-023 SHALL on rst=0, asynchronously: clear both holding valids, busy=0, rf_wr=0, rf_rd=0, rf_rw=0, counter=0, FSM=PRI_LD.
REQ-024 SHALL discard in-flight holding entries on reset mid-operation; acks SHALL read 1 while rst=0.
REQ-025 SHALL hold byp_* outputs at 0 during reset.

Configuration
REQ-026 SHALL with macro REGFILE_WB_BYPASS_EN defined drive byp_rs_hit = rf_wr & (rf_rd==rs_q), byp_rt_hit = rf_wr & (rf_rd==rt_q), byp_data = rf_rw.
REQ-027 SHALL without REGFILE_WB_BYPASS_EN keep the byp_* ports and tie them to 0.

Verification
REQ-028 SHALL check: single ALU write rd=5 data=16'hBEEF at E0 -> rf_wr=1, rf_rd=5, rf_rw=16'hBEEF after E1 only; busy[5] cleared at E1.
REQ-029 SHALL check: both channels request every cycle, distinct rd, STARVE_LIMIT=3 -> grant pattern LD,LD,LD,ALU repeating, no lost transfers.
REQ-030 SHALL check: both entries captured same edge with rd=7 (ld 16'h1111, alu 16'h2222) -> rf_rw 16'h1111 then 16'h2222 on consecutive cycles.
REQ-031 SHALL check: iss_valid rd=3 on the edge a grant writes rd=3 -> busy[3]=1 afterwards; rs_q=3 gives rs_busy=1.
REQ-032 SHALL check: rst=0 asserted mid-stream with both entries valid -> rf_wr=0 and busy=0 immediately (no clock), no writes issued after release.
REQ-033 SHALL check: with REGFILE_WB_BYPASS_EN, rf_wr=1, rf_rd=9, rs_q=9 -> byp_rs_hit=1, byp_data=rf_rw; without macro -> 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Merges the ALU and load writeback channels into the single register-file
// write port. It also keeps a busy scoreboard for registers whose writeback
// is still outstanding.
//
// Each channel has one holding entry. The arbiter grants at most one entry
// per cycle. That grant is registered onto rf_wr/rf_rd/rf_rw at the same
// edge, so the register file sees the write one cycle later.
//
// Grant policy:
//   * Load entries are normally preferred.
//   * A 2-bit starve counter limits how many consecutive load grants the
//     ALU entry can lose. Once the counter reaches the limit, the ALU entry
//     is preferred until it is served.
//   * If both entries target the same rd, the older entry always wins, so
//     the two writes to that register stay in order.
//
// Optional feature (compile-time macro):
//   REGFILE_WB_BYPASS_EN - drive byp_* from the registered write port.
//                          When undefined, byp_* are tied to 0.
//
// Parameters:
//   STARVE_LIMIT - max consecutive load grants while an ALU entry waits (1-3)
//
// Ports:
//   clk, rst                      - clock (rising edge), async active-low reset
//   alu_req/rd/data, alu_ack      - ALU writeback channel
//   ld_req/rd/data, ld_ack        - load writeback channel
//   iss_valid, iss_rd             - issued instruction that will write iss_rd
//   rs_q, rt_q, rs_busy, rt_busy  - scoreboard query
//   rf_wr, rf_rd, rf_rw           - registered register-file write port
//   byp_rs_hit, byp_rt_hit,
//   byp_data                      - writeback bypass
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_req,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_ack,
  input  logic        ld_req,
  input  logic [3:0]  ld_rd,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  input  logic        iss_valid,
  input  logic [3:0]  iss_rd,
  input  logic [3:0]  rs_q,
  input  logic [3:0]  rt_q,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        rf_wr,
  output logic [3:0]  rf_rd,
  output logic [15:0] rf_rw,
  output logic        byp_rs_hit,
  output logic        byp_rt_hit,
  output logic [15:0] byp_data
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  typedef enum logic {
    PRI_LD  = 1'b0,
    PRI_ALU = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [1:0]  starve_cnt, starve_cnt_next;

  logic        ld_valid, alu_valid;
  logic [3:0]  ld_hold_rd, alu_hold_rd;
  logic [15:0] ld_hold_data, alu_hold_data;
  // Set when the ALU entry was captured before the current load entry.
  logic        alu_older;

  logic        grant_ld, grant_alu;
  logic        same_rd;
  logic        ld_take, alu_take;
  logic [15:0] busy, busy_next;

  assign same_rd  = ld_valid & alu_valid & (ld_hold_rd == alu_hold_rd);

  // An entry can accept new data in the same cycle it is being drained,
  // which keeps one write per cycle when a channel streams continuously.
  assign ld_ack   = ~ld_valid  | grant_ld;
  assign alu_ack  = ~alu_valid | grant_alu;
  assign ld_take  = ld_req  & ld_ack;
  assign alu_take = alu_req & alu_ack;

  // Grant selection plus next-state/starve-counter logic.
  always_comb begin
    grant_ld        = 1'b0;
    grant_alu       = 1'b0;
    state_next      = state;
    starve_cnt_next = starve_cnt;

    // Age ordering overrides the FSM when both entries target the same rd.
    if (same_rd) begin
      grant_alu = alu_older;
      grant_ld  = ~alu_older;
    end else if (ld_valid && alu_valid) begin
      grant_alu = (state == PRI_ALU);
      grant_ld  = (state == PRI_LD);
    end else begin
      grant_ld  = ld_valid;
      grant_alu = alu_valid;
    end

    case (state)
      PRI_LD: begin
        // The counter tracks consecutive load wins against a waiting ALU
        // entry. It restarts as soon as that entry is gone or served.
        if (!alu_valid || grant_alu) begin
          starve_cnt_next = 2'd0;
        end else if (grant_ld) begin
          starve_cnt_next = starve_cnt + 2'd1;
          if (starve_cnt + 2'd1 == LIMIT) begin
            state_next = PRI_ALU;
          end
        end
      end
      PRI_ALU: begin
        if (grant_alu || !alu_valid) begin
          state_next      = PRI_LD;
          starve_cnt_next = 2'd0;
        end
      end
      default: begin
        state_next      = PRI_LD;
        starve_cnt_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PRI_LD;
      starve_cnt <= 2'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Set wins over clear, so a register reissued on its own writeback edge
  // stays busy.
  always_comb begin
    busy_next = busy;
    if (grant_ld) begin
      busy_next[ld_hold_rd] = 1'b0;
    end else if (grant_alu) begin
      busy_next[alu_hold_rd] = 1'b0;
    end
    if (iss_valid) begin
      busy_next[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid      <= 1'b0;
      ld_hold_rd    <= 4'd0;
      ld_hold_data  <= 16'd0;
      alu_valid     <= 1'b0;
      alu_hold_rd   <= 4'd0;
      alu_hold_data <= 16'd0;
      alu_older     <= 1'b0;
      rf_wr         <= 1'b0;
      rf_rd         <= 4'd0;
      rf_rw         <= 16'd0;
      busy          <= 16'd0;
    end else begin
      if (ld_take) begin
        ld_valid     <= 1'b1;
        ld_hold_rd   <= ld_rd;
        ld_hold_data <= ld_data;
      end else if (grant_ld) begin
        ld_valid <= 1'b0;
      end

      if (alu_take) begin
        alu_valid     <= 1'b1;
        alu_hold_rd   <= alu_rd;
        alu_hold_data <= alu_data;
      end else if (grant_alu) begin
        alu_valid <= 1'b0;
      end

      // A new load entry is younger than an ALU entry that survives this
      // edge. A new ALU entry is never older than the load entry. When both
      // are captured together, the load counts as older.
      if (ld_take) begin
        alu_older <= alu_valid & ~grant_alu;
      end else if (alu_take) begin
        alu_older <= 1'b0;
      end

      if (grant_ld) begin
        rf_wr <= 1'b1;
        rf_rd <= ld_hold_rd;
        rf_rw <= ld_hold_data;
      end else if (grant_alu) begin
        rf_wr <= 1'b1;
        rf_rd <= alu_hold_rd;
        rf_rw <= alu_hold_data;
      end else begin
        rf_wr <= 1'b0;
      end

      busy <= busy_next;
    end
  end

  assign rs_busy = busy[rs_q];
  assign rt_busy = busy[rt_q];

`ifdef REGFILE_WB_BYPASS_EN
  // rf_wr and rf_rw are cleared by reset, so the bypass reads 0 in reset.
  assign byp_rs_hit = rf_wr & (rf_rd == rs_q);
  assign byp_rt_hit = rf_wr & (rf_rd == rt_q);
  assign byp_data   = rf_rw;
`else
  assign byp_rs_hit = 1'b0;
  assign byp_rt_hit = 1'b0;
  assign byp_data   = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter.
//
// A reference model tracks:
//   * each channel's pending entry, with a capture timestamp for age,
//   * how many times in a row the ALU entry has lost to a load,
//   * the busy registers.
//
// On every clock edge the model pushes the write it predicts into a queue.
// A separate monitor compares the DUT's write port and bypass outputs
// against the head of that queue.
module tb_regfile_wb_arbiter;

  localparam int STARVE_LIMIT = 3;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_req, ld_req, iss_valid;
  logic [3:0]  alu_rd, ld_rd, iss_rd, rs_q, rt_q;
  logic [15:0] alu_data, ld_data;
  logic        alu_ack, ld_ack, rs_busy, rt_busy, rf_wr;
  logic [3:0]  rf_rd;
  logic [15:0] rf_rw, byp_data;
  logic        byp_rs_hit, byp_rt_hit;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ack(alu_ack),
    .ld_req(ld_req), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ack(ld_ack),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs_q(rs_q), .rt_q(rt_q), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_rw(rf_rw),
    .byp_rs_hit(byp_rs_hit), .byp_rt_hit(byp_rt_hit), .byp_data(byp_data)
  );

  typedef struct {
    bit          valid;
    logic [3:0]  rd;
    logic [15:0] data;
    int          stamp;
  } entry_t;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } wr_t;

  entry_t      modelLd, modelAlu;
  int          aluLosses;
  int          edgeCount = 0;
  int          pushCount = 0;
  bit          modelBusy [16];
  wr_t         expQ [$];
  logic [3:0]  writeLog [$];
  logic [15:0] lastData;
  int          checks = 0;
  int          passes = 0;

  // Count a comparison and report it when the actual value differs.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Clear all model state, as a reset does to the DUT.
  function automatic void modelClear();
    modelLd.valid  = 1'b0;
    modelLd.stamp  = 0;
    modelAlu.valid = 1'b0;
    modelAlu.stamp = 0;
    aluLosses      = 0;
    foreach (modelBusy[i]) modelBusy[i] = 1'b0;
    expQ.delete();
    lastData = 16'h0;
  endfunction

  // Decide which pending entry the arbiter should serve.
  // Rules, in order:
  //   1. Two writes to the same register go oldest first.
  //   2. Otherwise the ALU entry wins once it has lost STARVE_LIMIT times in a row.
  //   3. Otherwise the load entry wins.
  //   4. A lone pending entry is always served.
  function automatic void decide(output bit gl, output bit ga);
    gl = 1'b0;
    ga = 1'b0;
    if (modelLd.valid && modelAlu.valid) begin
      if (modelLd.rd == modelAlu.rd) begin
        if (modelAlu.stamp < modelLd.stamp) ga = 1'b1;
        else gl = 1'b1;
      end else if (aluLosses >= STARVE_LIMIT) ga = 1'b1;
      else gl = 1'b1;
    end else if (modelLd.valid) gl = 1'b1;
    else if (modelAlu.valid) ga = 1'b1;
  endfunction

  // Advance the model across one rising edge, using the inputs currently driven.
  task automatic modelEdge();
    bit  gl, ga, ldAckNow, aluAckNow;
    wr_t w;
    decide(gl, ga);
    ldAckNow  = !modelLd.valid || gl;
    aluAckNow = !modelAlu.valid || ga;
    if (gl) begin
      w.rd = modelLd.rd;
      w.data = modelLd.data;
      expQ.push_back(w);
      pushCount++;
      modelBusy[modelLd.rd] = 1'b0;
    end
    if (ga) begin
      w.rd = modelAlu.rd;
      w.data = modelAlu.data;
      expQ.push_back(w);
      pushCount++;
      modelBusy[modelAlu.rd] = 1'b0;
    end
    if (!modelAlu.valid || ga) aluLosses = 0;
    else if (gl) aluLosses++;
    if (iss_valid) modelBusy[iss_rd] = 1'b1;
    if (gl) modelLd.valid = 1'b0;
    if (ga) modelAlu.valid = 1'b0;
    if (ld_req && ldAckNow) modelLd = '{1'b1, ld_rd, ld_data, 2 * edgeCount};
    if (alu_req && aluAckNow) modelAlu = '{1'b1, alu_rd, alu_data, 2 * edgeCount + 1};
    edgeCount++;
  endtask

  // Drive one cycle of inputs, check the acks and busy flags against the
  // model, then step the model over the next rising edge.
  task automatic applyStimulus(input bit lr, input logic [3:0] lrd, input logic [15:0] ldd,
                               input bit ar, input logic [3:0] ard, input logic [15:0] ad,
                               input bit iv, input logic [3:0] ird,
                               input logic [3:0] rs, input logic [3:0] rt);
    bit gl, ga;
    @(negedge clk);
    #1;
    ld_req = lr;
    ld_rd = lrd;
    ld_data = ldd;
    alu_req = ar;
    alu_rd = ard;
    alu_data = ad;
    iss_valid = iv;
    iss_rd = ird;
    rs_q = rs;
    rt_q = rt;
    #1;
    decide(gl, ga);
    checkOutput("ld_ack", ld_ack, !modelLd.valid || gl);
    checkOutput("alu_ack", alu_ack, !modelAlu.valid || ga);
    checkOutput("rs_busy", rs_busy, modelBusy[rs]);
    checkOutput("rt_busy", rt_busy, modelBusy[rt]);
    @(posedge clk);
    modelEdge();
  endtask

  // Run n cycles with no requests and no issue.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the write port and bypass outputs with the predicted write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        wr_t w;
        bit  have;
        have = (expQ.size() > 0);
        if (have) w = expQ[0];
        checkOutput("byp_rs_hit", byp_rs_hit, BYP && have && (w.rd == rs_q));
        checkOutput("byp_rt_hit", byp_rt_hit, BYP && have && (w.rd == rt_q));
        checkOutput("byp_data", byp_data, BYP ? (have ? w.data : lastData) : 16'h0);
        checkOutput("rf_wr", rf_wr, have);
        if (rf_wr === 1'b1) writeLog.push_back(rf_rd);
        if (have) begin
          checkOutput("rf_rd", rf_rd, w.rd);
          checkOutput("rf_rw", rf_rw, w.data);
          lastData = w.data;
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    int snap;
    rst = 1'b0;
    ld_req = 0; ld_rd = 0; ld_data = 0;
    alu_req = 0; alu_rd = 0; alu_data = 0;
    iss_valid = 0; iss_rd = 0; rs_q = 0; rt_q = 0;
    modelClear();

    // Reset state
    #3;
    checkOutput("reset rf_wr", rf_wr, 0);
    checkOutput("reset rf_rd", rf_rd, 0);
    checkOutput("reset rf_rw", rf_rw, 0);
    checkOutput("reset ld_ack", ld_ack, 1);
    checkOutput("reset alu_ack", alu_ack, 1);
    checkOutput("reset rs_busy", rs_busy, 0);
    checkOutput("reset byp_rs_hit", byp_rs_hit, 0);
    checkOutput("reset byp_data", byp_data, 0);
    @(negedge clk);
    #1 rst = 1'b1;

    // Single ALU write rd=5: issue, handshake at E0, write registered at E1
    $display("[TB] single ALU write");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    applyStimulus(0, 0, 0, 1, 5, 16'hBEEF, 0, 0, 5, 0);
    #1;
    checkOutput("E0 rf_wr", rf_wr, 0);
    checkOutput("E0 rs_busy", rs_busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    checkOutput("E1 rf_wr", rf_wr, 1);
    checkOutput("E1 rf_rd", rf_rd, 5);
    checkOutput("E1 rf_rw", rf_rw, 16'hBEEF);
    checkOutput("E1 rs_busy", rs_busy, 0);
    idle(2);

    // Same-edge capture, equal rd: load first, then ALU
    $display("[TB] equal rd ordering");
    applyStimulus(1, 7, 16'h1111, 1, 7, 16'h2222, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("same rd first", rf_rw, 16'h1111);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("same rd second", rf_rw, 16'h2222);
    checkOutput("same rd second wr", rf_wr, 1);
    idle(2);

    // Issue on the same edge that writes back the same rd: set wins
    $display("[TB] issue vs clear");
    applyStimulus(0, 0, 0, 1, 3, 16'h3333, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    #1;
    checkOutput("set-wins rf_rd", rf_rd, 3);
    checkOutput("set-wins rs_busy", rs_busy, 1);
    idle(2);

    // Bypass of the registered write
    $display("[TB] bypass");
    applyStimulus(0, 0, 0, 1, 9, 16'h5A5A, 0, 0, 9, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    #1;
    checkOutput("bypass rf_rd", rf_rd, 9);
    checkOutput("bypass rs_hit", byp_rs_hit, BYP);
    checkOutput("bypass rt_hit", byp_rt_hit, BYP);
    checkOutput("bypass data", byp_data, BYP ? 16'h5A5A : 16'h0);
    idle(2);

    // Both channels streaming with distinct rd: LD,LD,LD,ALU repeating
    $display("[TB] starvation pattern");
    writeLog.delete();
    snap = pushCount;
    for (int i = 0; i < 16; i++)
      applyStimulus(1, 4'(i % 8), 16'($urandom), 1, 4'(8 + i % 8), 16'($urandom), 0, 0, 0, 0);
    idle(6);
    for (int k = 0; k < 12; k++)
      checkOutput($sformatf("grant pattern %0d", k), writeLog[k] >= 4'd8, (k % 4) == 3);
    checkOutput("stream write count", writeLog.size(), pushCount - snap);

    // Randomised traffic with frequent rd collisions
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 5)), 16'($urandom),
                    $urandom_range(0, 9) < 7, 4'($urandom_range(0, 5)), 16'($urandom),
                    $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(4);

    // Reset asserted mid-stream with both entries valid
    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 4'(i), 16'($urandom), 1, 4'(8 + i), 16'($urandom), 1, 2, 2, 10);
    #2;
    rst = 1'b0;
    ld_req = 0;
    alu_req = 0;
    iss_valid = 0;
    #1;
    checkOutput("async rst rf_wr", rf_wr, 0);
    checkOutput("async rst ld_ack", ld_ack, 1);
    checkOutput("async rst alu_ack", alu_ack, 1);
    checkOutput("async rst rs_busy", rs_busy, 0);
    checkOutput("async rst byp_rs_hit", byp_rs_hit, 0);
    modelClear();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    snap = writeLog.size();
    idle(4);
    checkOutput("no writes after reset", writeLog.size(), snap);

    idle(2);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
